fphub_norm_pack: RTL



---
 rtl/fphub_norm_pack_if.sv | 28 ++
 rtl/fphub_norm_pack.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fphub_norm_pack_if.sv
// Handshake bundle between the FPHUB mantissa adder, the normalize/pack stage and its consumer.
// slave is the normalize/pack side; master is the adder/consumer side.
interface fphub_norm_pack_if #(
  parameter int M = 24,
  parameter int E = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [M+1:0]   in_sum;
  logic [E-1:0]   in_exp;
  logic           in_sign;
  logic           out_valid;
  logic           out_ready;
  logic [E+M:0]   out_z;
  logic           out_zero;
  logic           out_ovf;
  logic           out_unf;

  modport slave (
    input  in_valid, in_sum, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_z, out_zero, out_ovf, out_unf
  );

  modport master (
    output in_valid, in_sum, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_z, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fphub_norm_pack.sv
// Normalizes a raw adder sum (carry/mantissa/ILSB) and packs it into a {sign, exp, frac} HUB word.
// Latency: 1 cycle for zero/carry/normalized sums, 1 + ceil(lz/SH) cycles for cancellation.
// Backpressure: single-entry; in_ready only in IDLE, result held stable until out_ready.
module fphub_norm_pack #(
  parameter int M  = 24,
  parameter int E  = 8,
  parameter int SH = 4
) (
  input logic               clk,
  input logic               rst_n,
  fphub_norm_pack_if.slave  bus
);
  localparam int LZW = $clog2(M + 1);
  localparam int CW  = ((E > LZW) ? E : LZW) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [M+1:0]   sum_q, sum_d;
  logic [E-1:0]   exp_q, exp_d;
  logic           sign_q, sign_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [LZW-1:0] lz;
  logic [LZW-1:0] step;

  // Leading-zero count over the mantissa field; the highest set bit wins.
  always_comb begin
    lz = LZW'(M);
    for (int i = 1; i <= M; i++) begin
      if (sum_q[i]) lz = LZW'(M - i);
    end
    step = (lz > LZW'(SH)) ? LZW'(SH) : lz;
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_sign;
          zero_d = 1'b0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (bus.in_sum[M+1:1] == '0) begin
            sum_d   = '0;
            exp_d   = '0;
            zero_d  = 1'b1;
            state_d = DONE;
          end else if (bus.in_sum[M+1]) begin
            state_d = DONE;
            if (&bus.in_exp) begin
              ovf_d = 1'b1;
              exp_d = '1;
              sum_d = {1'b0, {M{1'b1}}, 1'b0};
            end else begin
              exp_d = bus.in_exp + E'(1);
              sum_d = {1'b0, bus.in_sum[M+1:1]};
            end
          end else begin
            sum_d   = bus.in_sum;
            exp_d   = bus.in_exp;
            state_d = bus.in_sum[M] ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        // Exponent 0 is reserved, so a step that would reach it flushes instead.
        if (CW'(exp_q) <= CW'(step)) begin
          sum_d   = '0;
          exp_d   = '0;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          sum_d = sum_q << step;
          exp_d = exp_q - E'(step);
          if (lz <= LZW'(SH)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_z     = {sign_q, exp_q, sum_q[M:1]};
  assign bus.out_zero  = zero_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_unf   = unf_q;
endmodule
